// File: rtl/hc138_rr_arbiter.sv
// Round-robin arbiter for eight requesters that drives a 74HC138-style 3-to-8 decoder.
// It enforces a grant timeout and a guard gap with the decoder disabled between grants.
module hc138_rr_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned GUARD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [2:0] a,
    output logic       g1,
    output logic       g2a_n,
    output logic       g2b_n,
    output logic       gnt_valid,
    output logic [2:0] gnt_id,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GUARD
    } state_t;

    localparam logic [8:0] TMO_LAST   = 9'(TIMEOUT - 1);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr, ptr_d;
    logic [8:0] cnt, cnt_d;
    logic [3:0] gcnt, gcnt_d;
    logic [2:0] gnt_id_d;
    logic       terr_d;
    logic       win_found;
    logic [2:0] win_id;
    logic       rel;

    // First requester at or after ptr; the 3-bit add wraps 7 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        for (int i = 0; i < 8; i++) begin
            if (!win_found && req[ptr + 3'(i)]) begin
                win_found = 1'b1;
                win_id    = ptr + 3'(i);
            end
        end
    end

    assign rel = done[gnt_id] | ~req[gnt_id];

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr;
        cnt_d    = cnt;
        gcnt_d   = gcnt;
        gnt_id_d = gnt_id;
        terr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_GRANT;
                    gnt_id_d = win_id;
                    cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt + 9'd1;
                // A release that coincides with the timeout wins, so no error pulse.
                if (rel || cnt == TMO_LAST) begin
                    state_d = ST_GUARD;
                    terr_d  = ~rel;
                    ptr_d   = gnt_id + 3'd1;
                    gcnt_d  = '0;
                end
            end
            ST_GUARD: begin
                if (gcnt == GUARD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // Outputs are computed from the next state, so they stay purely registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            gnt_id      <= '0;
            a           <= '0;
            gnt_valid   <= 1'b0;
            g1          <= 1'b0;
            g2a_n       <= 1'b1;
            g2b_n       <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr         <= ptr_d;
            cnt         <= cnt_d;
            gcnt        <= gcnt_d;
            gnt_id      <= gnt_id_d;
            a           <= gnt_id_d;
            gnt_valid   <= (state_d == ST_GRANT);
            g1          <= (state_d == ST_GRANT);
            g2a_n       <= (state_d != ST_GRANT);
            g2b_n       <= (state_d != ST_GRANT);
            timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_hc138_rr_arbiter.sv
// Self-checking bench for hc138_rr_arbiter: a cycle model compared on every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hc138_rr_arbiter;

    localparam int TIMEOUT = 255;
    localparam int GUARD   = 1;

    localparam int M_IDLE  = 0;
    localparam int M_GRANT = 1;
    localparam int M_GUARD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] done = 8'h00;
    logic [2:0] a;
    logic       g1, g2a_n, g2b_n, gnt_valid, timeout_err;
    logic [2:0] gnt_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: phase, pointer, granted id, grant length so far, guard cycles left.
    int m_mode = M_IDLE;
    int m_ptr  = 0;
    int m_gid  = 0;
    int m_len  = 0;
    int m_left = 0;
    bit m_terr = 1'b0;
    bit m_found;

    logic [2:0] id;
    logic [2:0] seq[$];
    int         run, gap, hi;
    bit         seen, lost;

    hc138_rr_arbiter #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .a           (a),
        .g1          (g1),
        .g2a_n       (g2a_n),
        .g2b_n       (g2b_n),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_out();
        return {5'b0, gnt_valid, g1, g2a_n, g2b_n, timeout_err, a, gnt_id};
    endfunction

    function automatic logic [15:0] exp_pack(input bit v, input bit t, input logic [2:0] i);
        return {5'b0, v, v, ~v, ~v, t, i, i};
    endfunction

    // Reference behaviour, evaluated at each rising edge from the sampled inputs.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_mode = M_IDLE; m_ptr = 0; m_gid = 0; m_len = 0; m_left = 0; m_terr = 1'b0;
        end else if (m_mode == M_IDLE) begin
            m_terr = 1'b0;
            if (req != 8'h00) begin
                m_found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (!m_found && req[(m_ptr + i) % 8]) begin
                        m_found = 1'b1;
                        m_gid   = (m_ptr + i) % 8;
                    end
                end
                m_mode = M_GRANT;
                m_len  = 0;
            end
        end else if (m_mode == M_GRANT) begin
            m_len++;
            if (done[m_gid] || !req[m_gid] || m_len == TIMEOUT) begin
                m_terr = !(done[m_gid] || !req[m_gid]);
                m_ptr  = (m_gid + 1) % 8;
                m_left = GUARD;
                m_mode = M_GUARD;
            end
        end else begin
            m_terr = 1'b0;
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en)
            check("cycle", pack_out(), exp_pack(m_mode == M_GRANT, m_terr, 3'(m_gid)));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 8'h00;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic pulse_done(input logic [7:0] m);
        done = m;
        step();
        done = 8'h00;
    endtask

    task automatic wait_grant(input string name, input int budget, output logic [2:0] gid);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (gnt_valid === 1'b1) got = 1'b1;
        end
        check({name, "_arrive"}, 16'(got), 16'd1);
        gid = gnt_id;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_outputs", pack_out(), exp_pack(0, 0, 3'd0));

        // Single requester 0: grant in cycle 1, done in cycle 4, guard then idle.
        req = 8'h01;
        step();
        check("s32_grant", pack_out(), exp_pack(1, 0, 3'd0));
        step(); step(); step();
        check("s32_held", 16'(gnt_valid), 16'd1);
        done = 8'h01; req = 8'h00;
        step();
        done = 8'h00;
        check("s32_guard", pack_out(), exp_pack(0, 0, 3'd0));
        step();
        check("s32_idle", pack_out(), exp_pack(0, 0, 3'd0));

        // All requesting, each grant released after two cycles.
        do_reset();
        req = 8'hFF; run = 0; gap = 0; seen = 1'b0;
        seq.delete();
        for (int c = 0; c < 200 && seq.size() < 9; c++) begin
            step();
            done = 8'h00;
            if (gnt_valid) begin
                if (run == 0) begin
                    seq.push_back(gnt_id);
                    check("s33_a", 16'(a), 16'(gnt_id));
                    if (seen) check("s33_gap", 16'(gap), 16'(GUARD + 1));
                    gap = 0; seen = 1'b1;
                end
                run++;
                if (run == 2) done = 8'h01 << gnt_id;
            end else begin
                run = 0;
                gap++;
            end
        end
        done = 8'h00;
        check("s33_count", 16'(seq.size()), 16'd9);
        for (int i = 0; i < seq.size(); i++)
            check("s33_id", 16'(seq[i]), 16'(i % 8));

        // Wrap-around from ptr=3 with requesters 7 and 2.
        do_reset();
        req = 8'h04;
        wait_grant("s34_setup", 4, id);
        check("s34_setup_id", 16'(id), 16'd2);
        req = 8'h00;
        step(); step();
        req = 8'h84;
        wait_grant("s34_first", 4, id);
        check("s34_first_id", 16'(id), 16'd7);
        pulse_done(8'h80);
        wait_grant("s34_second", 4, id);
        check("s34_second_id", 16'(id), 16'd2);

        // Timeout on requester 4 with no release.
        do_reset();
        req = 8'h10;
        wait_grant("s35", 4, id);
        check("s35_id", 16'(id), 16'd4);
        hi = 1;
        for (int i = 0; i < 300 && gnt_valid; i++) begin
            step();
            if (gnt_valid) hi++;
        end
        check("s35_len", 16'(hi), 16'(TIMEOUT));
        check("s35_terr", 16'(timeout_err), 16'd1);
        step();
        check("s35_terr_end", pack_out(), exp_pack(0, 0, 3'd4));
        step();
        check("s35_regrant", pack_out(), exp_pack(1, 0, 3'd4));
        req = 8'h30;
        pulse_done(8'h10);
        wait_grant("s35_ptr", 4, id);
        check("s35_ptr_id", 16'(id), 16'd5);

        // Foreign done ignored; own done in the timeout cycle is a normal release.
        do_reset();
        req = 8'h20;
        wait_grant("s36", 8, id);
        check("s36_id", 16'(id), 16'd5);
        pulse_done(8'h08);
        check("s36_foreign", 16'(gnt_valid), 16'd1);
        lost = 1'b0;
        for (int i = 0; i < TIMEOUT - 2; i++) begin
            step();
            if (!gnt_valid) lost = 1'b1;
        end
        check("s36_hold", 16'(lost), 16'd0);
        pulse_done(8'h20);
        check("s36_release", pack_out(), exp_pack(0, 0, 3'd5));

        // Reset mid-grant clears outputs and the pointer.
        do_reset();
        req = 8'h02;
        wait_grant("s37_a", 4, id);
        check("s37_a_id", 16'(id), 16'd1);
        req = 8'h00;
        step(); step();
        req = 8'h06;
        wait_grant("s37_b", 4, id);
        check("s37_b_id", 16'(id), 16'd2);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s37_reset", pack_out(), exp_pack(0, 0, 3'd0));
        step();
        check("s37_restart", pack_out(), exp_pack(1, 0, 3'd1));

        // Randomized traffic, checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 8'($urandom) & 8'($urandom);
            done = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            rst  = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; done = 8'h00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
